// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits, OVERSAMPLE b_ticks per bit.
// Registered outputs; the line drops one clk after acceptance. tx_start is taken only while idle and never queued.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int              TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic            PAR_EN    = (PARITY_EN != 0);
  localparam logic            PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = b_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // The acceptance clk is not a bit-period clk, so a coincident b_tick is dropped.
    if (state_q != IDLE && b_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ PAR_ODD;
          tick_d  = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations checked against a frame-level model (bit list + tick arithmetic).
module tb_uart_tx;

  localparam int OS = 16;

  logic       clk;
  logic       rst;
  logic       b_tick;
  logic       tx_start [4];
  logic [7:0] tx_data  [4];
  logic       tx_o     [4];
  logic       busy_o   [4];
  logic       done_o   [4];

  int n_cmp = 0;
  int n_bad = 0;
  int bgap  = 4;

  // 0: 8N1   1: 8E1   2: 8O1   3: 5N2
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
    .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));
  uart_tx #(.DATA_BITS(5), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(tx_start[3]), .tx_data(tx_data[3][4:0]),
    .tx(tx_o[3]), .tx_busy(busy_o[3]), .tx_done(done_o[3]));

  function automatic int db(input int i);  return (i == 3) ? 5 : 8;        endfunction
  function automatic int pe(input int i);  return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int po(input int i);  return (i == 2) ? 1 : 0;        endfunction
  function automatic int sb(input int i);  return (i == 3) ? 2 : 1;        endfunction
  function automatic int nbits(input int i); return 1 + db(i) + pe(i) + sb(i); endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bgap = N: one b_tick every N clks; bgap = 0: random spacing 1..6 clks.
  initial begin
    int cnt;
    int g;
    b_tick = 1'b0;
    cnt = 0;
    g = 4;
    forever begin
      @(negedge clk);
      cnt++;
      if (cnt >= g) begin
        b_tick = 1'b1;
        cnt = 0;
        g = (bgap == 0) ? int'($urandom_range(1, 6)) : bgap;
      end else begin
        b_tick = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    @(negedge clk);
    tx_start[idx] = 1'b1;
    tx_data[idx]  = d;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the acceptance edge; follows the frame until tx_done.
  task automatic run_frame(input int idx, input logic [7:0] data, input bit chain,
                           input logic [7:0] nxt, input bit hold,
                           output int ticks, output logic par_obs);
    logic bits[$];
    logic [7:0] m;
    int nb, tick, cur, bad_tx, bad_bs, bound;
    bit done_seen, par_got;
    m = 8'((1 << db(idx)) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < db(idx); i++) bits.push_back(data[i]);
    if (pe(idx) != 0) bits.push_back(logic'(($countones(data & m) + po(idx)) % 2));
    for (int i = 0; i < sb(idx); i++) bits.push_back(1'b1);
    nb = bits.size();
    bound = nb * OS * 7 + 50;
    tick = 0; cur = 0; bad_tx = 0; bad_bs = 0;
    done_seen = 1'b0; par_got = 1'b0; par_obs = 1'b0;
    for (int cyc = 0; cyc < bound; cyc++) begin
      if (tick / OS != cur) begin
        chk($sformatf("d%0d data %0h bit%0d tx bad cycles", idx, data, cur), bad_tx, 0);
        chk($sformatf("d%0d data %0h bit%0d busy/done bad cycles", idx, data, cur), bad_bs, 0);
        cur = tick / OS;
        bad_tx = 0;
        bad_bs = 0;
      end
      if (tick == nb * OS) begin
        chk($sformatf("d%0d data %0h tx_done at end", idx, data), done_o[idx], 1);
        chk($sformatf("d%0d data %0h tx_busy at end", idx, data), busy_o[idx], 0);
        chk($sformatf("d%0d data %0h tx at end", idx, data), tx_o[idx], 1);
        done_seen = 1'b1;
        if (chain) begin
          tx_start[idx] = 1'b1;
          tx_data[idx]  = nxt;
        end else begin
          tx_start[idx] = 1'b0;
        end
        break;
      end
      if (tx_o[idx] !== bits[cur]) bad_tx++;
      if (busy_o[idx] !== 1'b1 || done_o[idx] !== 1'b0) bad_bs++;
      if (cur == 1 + db(idx) && !par_got) begin
        par_obs = tx_o[idx];
        par_got = 1'b1;
      end
      if (hold) tx_data[idx] = 8'($urandom);
      @(posedge clk);
      if (b_tick) tick++;
      #1;
    end
    chk($sformatf("d%0d data %0h frame finished in budget", idx, data), done_seen, 1);
    ticks = tick;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         gap;
    int         exp_len;
    bit         has_par;
    logic       exp_par;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int ticks, bad, idx, nf, tick;
    bit hold, ok;
    logic par;
    logic [7:0] d, nd;

    vecs[0] = '{0, 8'h55, 4, 10, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h07, 4, 11, 1'b1, 1'b1};
    vecs[2] = '{2, 8'h07, 4, 11, 1'b1, 1'b0};
    vecs[3] = '{3, 8'h13, 3,  8, 1'b0, 1'b0};
    vecs[4] = '{1, 8'hA5, 2, 11, 1'b1, 1'b0};
    vecs[5] = '{2, 8'h80, 1, 11, 1'b1, 1'b0};
    vecs[6] = '{0, 8'hFE, 5, 10, 1'b0, 1'b0};

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_start[i] = 1'b0;
      tx_data[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset d%0d {tx,busy,done}", i), {tx_o[i], busy_o[i], done_o[i]}, 3'b100);
    end
    rst = 1'b1;

    // Idle with ticks running and no requests.
    bgap = 4;
    for (int i = 0; i < 4; i++) begin
      bad = 0;
      repeat (125) begin
        @(negedge clk);
        if ({tx_o[i], busy_o[i], done_o[i]} !== 3'b100) bad++;
      end
      chk($sformatf("idle d%0d bad cycles", i), bad, 0);
    end

    foreach (vecs[v]) begin
      bgap = vecs[v].gap;
      repeat (5) @(negedge clk);
      send(vecs[v].idx, vecs[v].data);
      tx_start[vecs[v].idx] = 1'b0;
      run_frame(vecs[v].idx, vecs[v].data, 1'b0, 8'h00, 1'b0, ticks, par);
      chk($sformatf("vec%0d frame ticks", v), ticks, vecs[v].exp_len * OS);
      if (vecs[v].has_par) chk($sformatf("vec%0d parity bit", v), par, vecs[v].exp_par);
    end

    // Back-to-back: second request raised in the tx_done clk.
    bgap = 4;
    repeat (5) @(negedge clk);
    send(0, 8'hA3);
    tx_start[0] = 1'b0;
    run_frame(0, 8'hA3, 1'b1, 8'h0F, 1'b0, ticks, par);
    @(posedge clk);
    #1;
    tx_start[0] = 1'b0;
    run_frame(0, 8'h0F, 1'b0, 8'h00, 1'b0, ticks, par);
    chk("b2b second frame ticks", ticks, 10 * OS);

    // Request mid-frame is dropped.
    repeat (5) @(negedge clk);
    send(0, 8'hFF);
    tx_start[0] = 1'b0;
    fork
      run_frame(0, 8'hFF, 1'b0, 8'h00, 1'b0, ticks, par);
      begin
        repeat (200) @(negedge clk);
        tx_start[0] = 1'b1;
        tx_data[0]  = 8'h12;
        @(negedge clk);
        tx_start[0] = 1'b0;
      end
    join
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy_o[0] !== 1'b0 || tx_o[0] !== 1'b1) bad++;
    end
    chk("ignored request never sent", bad, 0);

    // Reset during data bit 3 of 0x00.
    repeat (5) @(negedge clk);
    send(0, 8'h00);
    tx_start[0] = 1'b0;
    tick = 0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (tick >= 4 * OS + 8) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      if (b_tick) tick++;
      #1;
    end
    chk("reached data bit 3", ok, 1);
    chk("data bit 3 of 0x00 is low", tx_o[0], 0);
    #2 rst = 1'b0;
    #1;
    chk("async reset {tx,busy,done}", {tx_o[0], busy_o[0], done_o[0]}, 3'b100);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o[0] !== 1'b0 || tx_o[0] !== 1'b1) bad++;
    end
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if ({tx_o[0], busy_o[0], done_o[0]} !== 3'b100) bad++;
    end
    chk("no tx_done after reset abort", bad, 0);
    send(0, 8'hC4);
    tx_start[0] = 1'b0;
    run_frame(0, 8'hC4, 1'b0, 8'h00, 1'b0, ticks, par);
    chk("post-reset frame ticks", ticks, 10 * OS);

    // Randomized frames, chaining and held requests with changing data.
    for (int r = 0; r < 10; r++) begin
      idx  = int'($urandom_range(0, 3));
      nf   = int'($urandom_range(1, 3));
      hold = 1'($urandom_range(0, 1));
      bgap = int'($urandom_range(0, 4));
      d    = 8'($urandom);
      repeat ($urandom_range(2, 9)) @(negedge clk);
      send(idx, d);
      if (!hold) tx_start[idx] = 1'b0;
      for (int f = 0; f < nf; f++) begin
        nd = 8'($urandom);
        run_frame(idx, d, f < nf - 1, nd, hold, ticks, par);
        chk($sformatf("rand%0d.%0d d%0d frame ticks", r, f, idx), ticks, nbits(idx) * OS);
        if (f < nf - 1) begin
          @(posedge clk);
          #1;
          if (!hold) tx_start[idx] = 1'b0;
        end
        d = nd;
      end
      tx_start[idx] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
